// File: rtl/uart_massiv_pkg.sv
// Shared constants and state encodings for the framed UART block link.
// The block transmitter uses the same header codes and word count.
package uart_massiv_pkg;

    localparam logic [7:0] CODE_START = 8'h23;
    localparam logic [7:0] CODE_1     = 8'h0A;
    localparam logic [7:0] CODE_2     = 8'h3A;

    localparam int N_WORDS_DEF = 1025;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_HDR2,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CRC_HI,
        ST_CRC_LO
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// Bit-level 8N1 deserialiser with 2-FF input synchroniser.
// Samples mid-bit, LSB first; a low stop bit reports err instead of a byte.
module uart_rx
    import uart_massiv_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       err
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

    logic      meta_q, sync_q, prev_q;
    rx_state_e st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic      valid_q, valid_d;
    logic      err_q, err_d;

    // Synchronise rx and keep the previous sample for falling-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state: start re-check at half bit, then full-bit sampling.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) begin
                    st_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sh_d  = {sync_q, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
                        st_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    st_d  = RX_IDLE;
                    if (sync_q) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    assign data  = sh_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: rtl/uart_rx_massiv.sv
// Frame receiver: header hunt, word reassembly into a FIFO, additive checksum.
// Framing errors and inter-byte timeouts abort a frame in progress.
module uart_rx_massiv
    import uart_massiv_pkg::*;
#(
    parameter int CLK_DIV     = 868,
    parameter int N_WORDS     = N_WORDS_DEF,
    parameter int TIMEOUT_CYC = 20 * CLK_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [15:0] fifo_data,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        err_crc,
    output logic        err_ovf,
    output logic        err_abort,
    output logic        busy
);

    localparam int NW = $clog2(N_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [NW-1:0] NW_LAST = NW'(N_WORDS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_err;

    state_e      st_q, st_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] sum_q, sum_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        crc_q, crc_d;
    logic        eovf_q, eovf_d;
    logic        abort_q, abort_d;
    logic        busy_q;

    logic [15:0]   word;
    logic [NW-1:0] cnt_inc;

    assign word    = {hi_q, byte_data};
    assign cnt_inc = cnt_q + NW'(1);

    uart_rx #(
        .CLK_DIV(CLK_DIV)
    ) u_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .data (byte_data),
        .valid(byte_valid),
        .err  (byte_err)
    );

    // Parser state, accumulators and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            hi_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            crc_q   <= 1'b0;
            eovf_q  <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            hi_q    <= hi_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            crc_q   <= crc_d;
            eovf_q  <= eovf_d;
            abort_q <= abort_d;
            busy_q  <= (st_q != ST_IDLE);
        end
    end

    // Next-state: aborts win over parsing; parsing moves only on byte_valid.
    always_comb begin
        st_d    = st_q;
        hi_d    = hi_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        crc_d   = 1'b0;
        eovf_d  = 1'b0;
        abort_d = 1'b0;
        if (st_q == ST_IDLE || byte_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
        if (st_q != ST_IDLE && !byte_valid
            && (byte_err || tmo_q == TMO_LAST)) begin
            st_d    = ST_IDLE;
            abort_d = 1'b1;
            tmo_d   = '0;
        end else if (byte_valid) begin
            case (st_q)
                ST_IDLE: begin
                    if (byte_data == CODE_START) st_d = ST_HDR1;
                end
                ST_HDR1: begin
                    if (byte_data == CODE_1) begin
                        st_d = ST_HDR2;
                    end else if (byte_data == CODE_START) begin
                        st_d = ST_HDR1;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
                ST_HDR2: begin
                    if (byte_data == CODE_2) begin
                        st_d  = ST_DATA_HI;
                        sum_d = '0;
                        cnt_d = '0;
                        ovf_d = 1'b0;
                    end else if (byte_data == CODE_START) begin
                        st_d = ST_HDR1;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
                ST_DATA_HI: begin
                    hi_d = byte_data;
                    st_d = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    sum_d = sum_q + word;
                    cnt_d = cnt_inc;
                    if (!fifo_full) begin
                        wr_d   = 1'b1;
                        data_d = word;
                    end else begin
                        eovf_d = 1'b1;
                        ovf_d  = 1'b1;
                    end
                    st_d = (cnt_inc == NW_LAST) ? ST_CRC_HI : ST_DATA_HI;
                end
                ST_CRC_HI: begin
                    hi_d = byte_data;
                    st_d = ST_CRC_LO;
                end
                ST_CRC_LO: begin
                    done_d = 1'b1;
                    ok_d   = (word == sum_q) && !ovf_q;
                    crc_d  = (word != sum_q);
                    st_d   = ST_IDLE;
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    assign fifo_data  = data_q;
    assign fifo_wr_en = wr_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;
    assign err_crc    = crc_q;
    assign err_ovf    = eovf_q;
    assign err_abort  = abort_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_massiv.sv
// Scoreboard bench for uart_rx_massiv: frames are modelled as event lists
// (writes, overflows, done, aborts) and a monitor matches DUT outputs in order.
module tb_uart_rx_massiv;

    localparam int CLK_DIV = 16;
    localparam int NW      = 4;
    localparam int TMO     = 320;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        fifo_full = 1'b0;
    logic [15:0] fifo_data;
    logic        fifo_wr_en;
    logic        frame_done;
    logic        frame_ok;
    logic        err_crc;
    logic        err_ovf;
    logic        err_abort;
    logic        busy;

    always #5 clk = ~clk;

    uart_rx_massiv #(
        .CLK_DIV    (CLK_DIV),
        .N_WORDS    (NW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .fifo_data (fifo_data),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full (fifo_full),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .err_crc   (err_crc),
        .err_ovf   (err_ovf),
        .err_abort (err_abort),
        .busy      (busy)
    );

    typedef enum int { EV_WR, EV_OVF, EV_DONE, EV_ABORT } kind_e;
    typedef struct {
        kind_e       kind;
        logic [15:0] data;
        logic        ok;
        logic        crc;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    logic [15:0] wbuf [NW];

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t",
                     name, act, req, $time);
        end
    endfunction

    function automatic void push(kind_e k, logic [15:0] d,
                                 logic ok, logic crc);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.ok   = ok;
        e.crc  = crc;
        exp_q.push_back(e);
    endfunction

    function automatic void pop_check(kind_e k, logic [15:0] d,
                                      logic ok, logic crc);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d required none at %0t",
                     int'(k), $time);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", int'(k), int'(e.kind));
        if (k == e.kind && k == EV_WR) check("fifo_data", d, e.data);
        if (k == e.kind && k == EV_DONE) begin
            check("frame_ok", ok, e.ok);
            check("err_crc", crc, e.crc);
        end
    endfunction

    // Monitor: every output strobe consumes one expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_crc && !frame_done) begin
                checks++;
                errors++;
                $display("FAIL err_crc_alone: got 1 required 0 at %0t", $time);
            end
            if (frame_ok && !frame_done) begin
                checks++;
                errors++;
                $display("FAIL frame_ok_alone: got 1 required 0 at %0t", $time);
            end
            if (fifo_wr_en) pop_check(EV_WR, fifo_data, 1'b0, 1'b0);
            if (err_ovf)    pop_check(EV_OVF, 16'h0, 1'b0, 1'b0);
            if (err_abort)  pop_check(EV_ABORT, 16'h0, 1'b0, 1'b0);
            if (frame_done) pop_check(EV_DONE, 16'h0, frame_ok, err_crc);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        wait_cyc(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CLK_DIV);
        end
        rx = stop;
        wait_cyc(CLK_DIV);
        rx = 1'b1;
        wait_cyc(2);
    endtask

    // Reference: expected events from words, checksum and full mask.
    task automatic model_frame(input logic [15:0] cks,
                               input logic [NW-1:0] fullm);
        int sum = 0;
        for (int i = 0; i < NW; i++) begin
            sum += int'(wbuf[i]);
            if (fullm[i]) push(EV_OVF, 16'h0, 1'b0, 1'b0);
            else          push(EV_WR, wbuf[i], 1'b0, 1'b0);
        end
        sum = sum % 65536;
        push(EV_DONE, 16'h0,
             (int'(cks) == sum) && (fullm == '0),
             int'(cks) != sum);
    endtask

    task automatic send_frame(input logic [15:0] cks,
                              input logic [NW-1:0] fullm,
                              input int junk, input bit resync);
        logic [7:0] b;
        model_frame(cks, fullm);
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom);
            if (b == 8'h23) b = 8'h24;
            send_byte(b);
        end
        if (resync) send_byte(8'h23);
        send_byte(8'h23);
        send_byte(8'h0A);
        send_byte(8'h3A);
        check("busy_in_frame", busy, 1'b1);
        for (int i = 0; i < NW; i++) begin
            fifo_full = fullm[i];
            send_byte(wbuf[i][15:8]);
            send_byte(wbuf[i][7:0]);
            fifo_full = 1'b0;
            wait_cyc($urandom_range(0, 12));
        end
        send_byte(cks[15:8]);
        send_byte(cks[7:0]);
        wait_cyc(4);
        check("busy_after_frame", busy, 1'b0);
    endtask

    task automatic set_words(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
        wbuf[0] = a;
        wbuf[1] = b;
        wbuf[2] = c;
        wbuf[3] = d;
    endtask

    initial begin
        int          sum;
        logic [15:0] cks;
        logic [NW-1:0] fm;
        int          budget;

        wait_cyc(3);
        check("reset_outputs",
              {fifo_data, fifo_wr_en, frame_done, frame_ok, err_crc,
               err_ovf, err_abort, busy}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(5);

        set_words(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        send_frame(16'h1014, '0, 0, 1'b0);
        send_frame(16'h1015, '0, 0, 1'b0);

        set_words(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000);
        send_frame(16'hFFFF, '0, 1, 1'b1);

        set_words(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        send_frame(16'h1014, 4'b0010, 0, 1'b0);

        push(EV_ABORT, 16'h0, 1'b0, 1'b0);
        send_byte(8'h23);
        send_byte(8'h0A);
        send_byte(8'h3A);
        send_byte(8'h01);
        send_byte(8'h02, 1'b0);
        wait_cyc(8);
        check("busy_after_ferr", busy, 1'b0);

        push(EV_WR, 16'h0102, 1'b0, 1'b0);
        push(EV_ABORT, 16'h0, 1'b0, 1'b0);
        send_byte(8'h23);
        send_byte(8'h0A);
        send_byte(8'h3A);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        wait_cyc(400);
        check("busy_after_timeout", busy, 1'b0);

        send_frame(16'h1014, '0, 0, 1'b0);

        push(EV_WR, 16'h0102, 1'b0, 1'b0);
        send_byte(8'h23);
        send_byte(8'h0A);
        send_byte(8'h3A);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("busy_mid_data", busy, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {fifo_data, fifo_wr_en, frame_done, frame_ok, err_crc,
               err_ovf, err_abort, busy}, 32'h0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(4);
        send_frame(16'h1014, '0, 0, 1'b0);

        for (int f = 0; f < 10; f++) begin
            sum = 0;
            for (int i = 0; i < NW; i++) begin
                wbuf[i] = 16'($urandom);
                sum += int'(wbuf[i]);
            end
            cks = 16'(sum);
            if ($urandom_range(0, 3) == 0) cks = cks ^ 16'(1 << $urandom_range(0, 15));
            fm = '0;
            if ($urandom_range(0, 3) == 0) fm[$urandom_range(0, NW - 1)] = 1'b1;
            send_frame(cks, fm, $urandom_range(0, 2), bit'($urandom_range(0, 1)));
        end

        budget = 2000;
        while (exp_q.size() != 0 && budget > 0) begin
            wait_cyc(1);
            budget--;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
